mc_ctrl: RTL and testbench

//  Multi-cycle control FSM sequencing the CPU datapath (pc, im/dm port, gpr, alu) over several cycles per instruction.

---
 rtl/mc_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
`timescale 1ns/1ps
// mc_ctrl: multi-cycle control FSM for a small MIPS-like datapath (addu, subu, ori, lw, sw, beq, j).
// Drives all datapath strobes, handshakes with a variable-latency memory and traps on bad opcodes/timeouts.
module mc_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,  ST_DECODE = 4'd1,  ST_EXEC_R = 4'd2,  ST_EXEC_I = 4'd3,
    ST_WB_R   = 4'd4,  ST_WB_I   = 4'd5,  ST_ADDR   = 4'd6,  ST_MEM_RD = 4'd7,
    ST_MEM_WR = 4'd8,  ST_WB_M   = 4'd9,  ST_BRANCH = 4'd10, ST_JUMP   = 4'd11,
    ST_TRAP   = 4'd12
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt;
  logic       mem_phase;
  logic       in_trap;
  ctl_t       ctl, ctl_out;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    mem_phase = 1'b0;
    in_trap   = 1'b0;
    ctl       = '0;
    case (state_q)
      ST_FETCH: begin
        mem_phase     = 1'b1;
        ctl.mem_req   = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.alu_op    = ALU_ADD;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ctl.alu_src_b = 2'b11;
        ctl.alu_op    = ALU_ADD;
        case (op)
          OP_RTYPE:     state_d = (funct == FN_ADDU || funct == FN_SUBU) ? ST_EXEC_R : ST_TRAP;
          OP_ORI:       state_d = ST_EXEC_I;
          OP_LW, OP_SW: state_d = ST_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_TRAP;
        endcase
      end
      ST_EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
        state_d       = ST_WB_R;
      end
      ST_EXEC_I: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_op    = ALU_OR;
        state_d       = ST_WB_I;
      end
      ST_WB_R: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_WB_I: begin
        ctl.reg_write = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_op    = ALU_ADD;
        state_d       = (op == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem_phase   = 1'b1;
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
        if (mem_ready) state_d = ST_WB_M;
      end
      ST_MEM_WR: begin
        mem_phase   = 1'b1;
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
        ctl.mem_we  = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_WB_M: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        state_d        = ST_FETCH;
      end
      ST_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALU_SUB;
        ctl.pc_src    = 2'b01;
        ctl.pc_write  = zero;
        state_d       = ST_FETCH;
      end
      ST_JUMP: begin
        ctl.pc_src   = 2'b10;
        ctl.pc_write = 1'b1;
        state_d      = ST_FETCH;
      end
      default: begin
        // TRAP and the unused codes 13-15 all park here until reset.
        in_trap = 1'b1;
        state_d = ST_TRAP;
      end
    endcase
    // A ready on the final allowed wait cycle still completes the access.
    if (mem_phase && !mem_ready && wait_cnt == WAIT_LAST) state_d = ST_TRAP;
  end

  // NOTE: reset is asynchronous and puts the FSM in FETCH, which would raise mem_req, so the
  // strobes are gated combinationally to stay low for as long as reset is held.
  assign ctl_out    = reset ? ctl : '0;
  assign mem_req    = ctl_out.mem_req;
  assign mem_we     = ctl_out.mem_we;
  assign iord       = ctl_out.iord;
  assign ir_write   = ctl_out.ir_write;
  assign pc_write   = ctl_out.pc_write;
  assign pc_src     = ctl_out.pc_src;
  assign reg_write  = ctl_out.reg_write;
  assign reg_dst    = ctl_out.reg_dst;
  assign mem_to_reg = ctl_out.mem_to_reg;
  assign alu_src_a  = ctl_out.alu_src_a;
  assign alu_src_b  = ctl_out.alu_src_b;
  assign alu_op     = ctl_out.alu_op;
  assign state      = state_q;

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mem_phase && !mem_ready && state_d == state_q) wait_cnt <= wait_cnt + 8'd1;
      else                                               wait_cnt <= '0;
      if (in_trap) illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
`timescale 1ns/1ps
// tb_mc_ctrl: self-checking bench for mc_ctrl. A per-instruction phase-plan model predicts
// every output each cycle; table vectors, corner sequences and random traffic drive it.
module tb_mc_ctrl;

  localparam int TIMEOUT = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       illegal;
  logic [3:0] state;

  mc_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
    .state(state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
  } obs_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int          len;
    logic [19:0] path;   // expected state per cycle, cycle 0 in the low nibble
    string       name;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: current phase number plus the remaining phases planned at decode.
  int m_cur;
  int m_wait;
  bit m_illegal;
  int m_plan[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = '{state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, reg_dst,
          mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal};
    return o;
  endfunction

  task automatic model_reset();
    m_cur = 0;
    m_wait = 0;
    m_illegal = 1'b0;
    m_plan.delete();
  endtask

  function automatic int next_phase();
    if (m_plan.size() > 0) return m_plan.pop_front();
    return 0;
  endfunction

  function automatic obs_t model_out();
    obs_t e;
    e = '0;
    e.state   = 4'(m_cur);
    e.illegal = m_illegal;
    case (m_cur)
      0:  begin
            e.mem_req = 1'b1; e.alu_src_b = 2'b01;
            if (mem_ready) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
          end
      1:  e.alu_src_b = 2'b11;
      2:  begin e.alu_src_a = 1'b1; e.alu_op = (funct == 6'h23) ? 3'b001 : 3'b000; end
      3:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b010; end
      4:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
      5:  e.reg_write = 1'b1;
      6:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      7:  begin e.mem_req = 1'b1; e.iord = 1'b1; end
      8:  begin e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1; end
      9:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
      10: begin e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_src = 2'b01; e.pc_write = zero; end
      11: begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic model_advance();
    int old;
    old = m_cur;
    case (m_cur)
      0, 7, 8: begin
        if (mem_ready) begin
          m_wait = 0;
          m_cur = (m_cur == 0) ? 1 : next_phase();
        end else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            m_cur = 12;
            m_wait = 0;
            m_plan.delete();
          end
        end
      end
      1: begin
        if (op == 6'h00 && (funct == 6'h21 || funct == 6'h23)) m_plan = '{2, 4};
        else if (op == 6'h0D)                                   m_plan = '{3, 5};
        else if (op == 6'h23)                                   m_plan = '{6, 7, 9};
        else if (op == 6'h2B)                                   m_plan = '{6, 8};
        else if (op == 6'h04)                                   m_plan = '{10};
        else if (op == 6'h02)                                   m_plan = '{11};
        else                                                    m_plan = '{12};
        m_cur = next_phase();
      end
      12: ;
      default: m_cur = next_phase();
    endcase
    if (old == 12) m_illegal = 1'b1;
  endtask

  // One clock: inputs applied just after the rising edge, outputs compared on the falling edge.
  task automatic step(input logic rdy, input logic z, input string tag, output obs_t got);
    obs_t exp;
    mem_ready = rdy;
    zero = z;
    @(negedge clock);
    got = sample();
    exp = model_out();
    check(tag, 32'(got), 32'(exp));
    model_advance();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #2;
    check("reset_outputs_low", 32'(sample()), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic pick_instr();
    int k;
    k = $urandom_range(0, 9);
    funct = 6'($urandom);
    case (k)
      0, 8: begin op = 6'h00; funct = 6'h21; end
      1:    begin op = 6'h00; funct = 6'h23; end
      2:    op = 6'h0D;
      3, 7: op = 6'h23;
      4:    op = 6'h2B;
      5:    op = 6'h04;
      6:    op = 6'h02;
      default: begin
        if ($urandom_range(0, 1) == 0) op = 6'h3F;
        else begin op = 6'h00; funct = 6'h20; end
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    obs_t got;
    vec_t vecs[8];
    int   cycles, req_cycles, stalls, trap_age;
    logic rdy, wb_m2r;

    vecs[0] = '{6'h00, 6'h21, 1'b0, 4, 20'h04210, "addu"};
    vecs[1] = '{6'h00, 6'h23, 1'b1, 4, 20'h04210, "subu"};
    vecs[2] = '{6'h0D, 6'h3F, 1'b0, 4, 20'h05310, "ori"};
    vecs[3] = '{6'h23, 6'h00, 1'b0, 5, 20'h97610, "lw"};
    vecs[4] = '{6'h2B, 6'h00, 1'b1, 4, 20'h08610, "sw"};
    vecs[5] = '{6'h04, 6'h00, 1'b1, 3, 20'h00A10, "beq_taken"};
    vecs[6] = '{6'h04, 6'h00, 1'b0, 3, 20'h00A10, "beq_not_taken"};
    vecs[7] = '{6'h02, 6'h00, 1'b0, 3, 20'h00B10, "j"};

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_state_and_strobes", 32'(sample()), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Table vectors with mem_ready always high: latency and state path per instruction.
    foreach (vecs[i]) begin
      op = vecs[i].op;
      funct = vecs[i].funct;
      for (int c = 0; c < vecs[i].len; c++) begin
        step(1'b1, vecs[i].zero, vecs[i].name, got);
        check({vecs[i].name, "_path"}, 32'(got.state), 32'(vecs[i].path[4*c +: 4]));
      end
    end
    step(1'b0, 1'b0, "idle_fetch", got);
    check("back_to_fetch", 32'(got.state), 32'd0);

    // lw with three not-ready cycles in MEM_RD.
    op = 6'h23;
    funct = 6'h00;
    cycles = 0; req_cycles = 0; stalls = 0; wb_m2r = 1'b0;
    do begin
      rdy = !(m_cur == 7 && stalls < 3);
      if (!rdy) stalls++;
      step(rdy, 1'b0, "lw_stall", got);
      cycles++;
      if (got.mem_req && got.iord) req_cycles++;
      if (got.state == 4'd9) wb_m2r = got.mem_to_reg;
    end while (cycles < 20 && got.state != 4'd9);
    check("lw_stall_total_cycles", 32'(cycles), 32'd8);
    check("lw_stall_mem_req_cycles", 32'(req_cycles), 32'd4);
    check("lw_stall_mem_to_reg", 32'(wb_m2r), 32'd1);

    // Illegal opcode: sticky trap with all strobes low, cleared only by reset.
    op = 6'h3F;
    step(1'b1, 1'b0, "illegal_fetch", got);
    step(1'b1, 1'b0, "illegal_decode", got);
    for (int c = 0; c < 22; c++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "illegal_hold", got);
    check("illegal_sticky", 32'(got.illegal), 32'd1);
    check("illegal_state_trap", 32'(got.state), 32'd12);
    apply_reset();
    step(1'b0, 1'b0, "post_trap_fetch", got);
    check("post_trap_illegal_clear", 32'(got.illegal), 32'd0);

    // FETCH timeout: TIMEOUT not-ready cycles trap; ready on the last one rescues.
    apply_reset();
    op = 6'h00;
    funct = 6'h21;
    for (int c = 0; c < TIMEOUT; c++) step(1'b0, 1'b0, "timeout_wait", got);
    step(1'b0, 1'b0, "timeout_trap", got);
    check("timeout_state", 32'(got.state), 32'd12);
    apply_reset();
    for (int c = 0; c < TIMEOUT - 1; c++) step(1'b0, 1'b0, "rescue_wait", got);
    step(1'b1, 1'b0, "rescue_ready", got);
    step(1'b0, 1'b0, "rescue_decode", got);
    check("rescue_state_decode", 32'(got.state), 32'd1);
    step(1'b1, 1'b0, "rescue_exec", got);
    step(1'b1, 1'b0, "rescue_wb", got);

    // Reset asserted in the middle of a stalled sw write.
    op = 6'h2B;
    step(1'b1, 1'b0, "sw_fetch", got);
    step(1'b1, 1'b0, "sw_decode", got);
    step(1'b1, 1'b0, "sw_addr", got);
    step(1'b0, 1'b0, "sw_memwr_wait", got);
    step(1'b0, 1'b0, "sw_memwr_wait", got);
    mem_ready = 1'b0;
    #2;
    got = sample();
    check("sw_before_reset_req_we", 32'({got.mem_req, got.mem_we}), 32'd3);
    reset = 1'b0;
    #1;
    got = sample();
    check("sw_reset_drop", 32'({got.mem_req, got.mem_we, got.pc_write, got.reg_write}), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    step(1'b0, 1'b0, "sw_after_reset", got);
    check("sw_after_reset_state", 32'(got.state), 32'd0);
    check("sw_after_reset_illegal", 32'(got.illegal), 32'd0);

    // Random traffic against the model.
    trap_age = 0;
    for (int n = 0; n < 800; n++) begin
      if (m_cur == 0) pick_instr();
      if (m_cur == 12) trap_age++;
      else trap_age = 0;
      if (trap_age > 4) begin
        apply_reset();
        trap_age = 0;
        pick_instr();
      end
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), "random", got);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
